// File: rtl/mux_pipe_hs.sv
// mux_pipe_hs: N-way registered multiplexer, valid/ready on both sides, 2-entry skid buffer.
// Optional macro MUX_PIPE_SEL_CHECK_EN: out-of-range selects are dropped and flagged on sel_err.
module mux_pipe_hs #(
   parameter int  WIDTH  = 32,
   parameter int  NUM_IN = 4,
   localparam int SEL_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SEL_W-1:0]          sel,
   input  logic [NUM_IN*WIDTH-1:0]   data_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          data_out,
   output logic [SEL_W-1:0]          out_sel,
   output logic                      sel_err
);

   logic               r_main_valid;
   logic [WIDTH-1:0]   r_main_data;
   logic [SEL_W-1:0]   r_main_sel;
   logic               r_skid_valid;
   logic [WIDTH-1:0]   r_skid_data;
   logic [SEL_W-1:0]   r_skid_sel;
   logic               r_in_ready;
   logic               r_sel_err;

   logic               w_accept;
   logic               w_enq;
   logic               w_drain;
   logic [WIDTH-1:0]   w_mux;

   logic               w_main_valid_nxt;
   logic [WIDTH-1:0]   w_main_data_nxt;
   logic [SEL_W-1:0]   w_main_sel_nxt;
   logic               w_skid_valid_nxt;
   logic [WIDTH-1:0]   w_skid_data_nxt;
   logic [SEL_W-1:0]   w_skid_sel_nxt;
   logic               w_sel_err_nxt;

   assign w_accept = in_valid && r_in_ready;
   assign w_drain  = r_main_valid && out_ready;

`ifdef MUX_PIPE_SEL_CHECK_EN
   localparam logic [SEL_W:0] LP_NUM_IN = (SEL_W+1)'(NUM_IN);
   logic w_oor;
   assign w_oor         = ({1'b0, sel} >= LP_NUM_IN);
   assign w_enq         = w_accept && !w_oor;
   assign w_sel_err_nxt = w_accept && w_oor;
`else
   assign w_enq         = w_accept;
   assign w_sel_err_nxt = 1'b0;
`endif

   // Operand select; an index with no matching input falls back to input 0.
   always_comb begin
      w_mux = data_in[WIDTH-1:0];
      for (int k = 1; k < NUM_IN; k++) begin
         w_mux = ({1'b0, sel} == (SEL_W+1)'(k)) ? data_in[k*WIDTH +: WIDTH] : w_mux;
      end
   end

   // Main/skid next state: drain first, then fill main, else park the beat in skid.
   always_comb begin
      w_main_valid_nxt = r_main_valid;
      w_main_data_nxt  = r_main_data;
      w_main_sel_nxt   = r_main_sel;
      w_skid_valid_nxt = r_skid_valid;
      w_skid_data_nxt  = r_skid_data;
      w_skid_sel_nxt   = r_skid_sel;
      if (w_drain) begin
         if (r_skid_valid) begin
            w_main_valid_nxt = 1'b1;
            w_main_data_nxt  = r_skid_data;
            w_main_sel_nxt   = r_skid_sel;
            w_skid_valid_nxt = 1'b0;
         end else if (w_enq) begin
            w_main_valid_nxt = 1'b1;
            w_main_data_nxt  = w_mux;
            w_main_sel_nxt   = sel;
         end else begin
            w_main_valid_nxt = 1'b0;
         end
      end else if (!r_main_valid) begin
         if (w_enq) begin
            w_main_valid_nxt = 1'b1;
            w_main_data_nxt  = w_mux;
            w_main_sel_nxt   = sel;
         end else begin
            w_main_valid_nxt = 1'b0;
         end
      end else begin
         if (w_enq) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = w_mux;
            w_skid_sel_nxt   = sel;
         end else begin
            w_skid_valid_nxt = r_skid_valid;
         end
      end
   end

   // State registers; in_ready is registered from the next skid state so out_ready never reaches it combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_valid <= 1'b0;
         r_main_data  <= '0;
         r_main_sel   <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_skid_sel   <= '0;
         r_in_ready   <= 1'b0;
         r_sel_err    <= 1'b0;
      end else begin
         r_main_valid <= w_main_valid_nxt;
         r_main_data  <= w_main_data_nxt;
         r_main_sel   <= w_main_sel_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         r_skid_data  <= w_skid_data_nxt;
         r_skid_sel   <= w_skid_sel_nxt;
         r_in_ready   <= !w_skid_valid_nxt;
         r_sel_err    <= w_sel_err_nxt;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_main_valid;
   assign data_out  = r_main_data;
   assign out_sel   = r_main_sel;
   assign sel_err   = r_sel_err;

endmodule
